flp_mul_pipe: RTL and testbench

- Elastic 3-stage pipelined floating point multiplier.
- Wraps the same unpack/multiply/normalize/round arithmetic as the combinational multiply test datapath, splitting it into three registered stages.
- Valid/ready handshakes on both sides.
- Sits between the vector operand issue logic and the result writeback path; instantiated with EWIDTH=8, SWIDTH=23 for FP32.

---
 rtl/flp_mul_pipe.sv | 143 ++++++++++++++
 tb/tb_flp_mul_pipe.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flp_mul_pipe.sv
// Elastic three-stage floating point multiplier: unpack/classify, significand multiply, normalize/round/pack.
// Optional macro FLP_MUL_PIPE_EXC_EN adds the registered o_exc {invalid, overflow, underflow} output.
module flp_mul_pipe #(
  parameter int EWIDTH = 8,
  parameter int SWIDTH = 23
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [EWIDTH+SWIDTH:0]   i_a,
  input  logic [EWIDTH+SWIDTH:0]   i_b,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [EWIDTH+SWIDTH:0]   o_p,
  output logic                     o_valid,
`ifdef FLP_MUL_PIPE_EXC_EN
  output logic [2:0]               o_exc,
`endif
  input  logic                     i_ready
);

  localparam int W  = EWIDTH + SWIDTH + 1;
  localparam int PW = 2 * SWIDTH + 2;
  localparam int XW = EWIDTH + 2;
  localparam logic signed [XW-1:0] BIAS = {3'b000, {(EWIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] EMAX = {2'b00, {EWIDTH{1'b1}}};
  localparam logic [W-1:0] QNAN = {1'b0, {EWIDTH{1'b1}}, 1'b1, {(SWIDTH-1){1'b0}}};

  // Round-to-nearest-even on a normalized significand (hidden bit already stripped).
  // Returns {carry, fraction}; a carry means the fraction wrapped to zero at the next binade.
  function automatic logic [SWIDTH:0] rne_round(input logic [PW-2:0] norm);
    logic [SWIDTH-1:0] frac;
    logic              rnd;
    frac = norm[PW-2 -: SWIDTH];
    rnd  = norm[SWIDTH] & ((|norm[SWIDTH-1:0]) | frac[0]);
    return {1'b0, frac} + {{SWIDTH{1'b0}}, rnd};
  endfunction

  function automatic logic [W-1:0] sat_pack(input logic sgn, input logic [2:0] cls,
                                            input logic signed [XW-1:0] exp,
                                            input logic [SWIDTH-1:0] frac);
    if (cls[2])           return QNAN;
    else if (cls[1])      return {sgn, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
    else if (cls[0])      return {sgn, {(W-1){1'b0}}};
    else if (exp >= EMAX) return {sgn, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
    else if (exp <= 0)    return {sgn, {(W-1){1'b0}}};
    else                  return {sgn, exp[EWIDTH-1:0], frac};
  endfunction

`ifdef FLP_MUL_PIPE_EXC_EN
  function automatic logic [2:0] exc_flags(input logic [2:0] cls, input logic signed [XW-1:0] exp);
    logic finite_nz;
    finite_nz = ~|cls;
    return {cls[2], finite_nz & (exp >= EMAX), finite_nz & (exp <= 0)};
  endfunction
`endif

  logic [EWIDTH-1:0] ea, eb;
  logic [SWIDTH-1:0] fa, fb;
  logic              en_p1, en_p2, en_p3;
  logic              vld_p1, vld_p2, vld_p3;

  assign ea = i_a[W-2 -: EWIDTH];
  assign eb = i_b[W-2 -: EWIDTH];
  assign fa = i_a[SWIDTH-1:0];
  assign fb = i_b[SWIDTH-1:0];

  // A stage may load when it is empty or its content moves on this edge.
  assign en_p3   = ~vld_p3 | i_ready;
  assign en_p2   = ~vld_p2 | en_p3;
  assign en_p1   = ~vld_p1 | en_p2;
  assign o_ready = en_p1;
  assign o_valid = vld_p3;

  // ---- stage 1: unpack and classify ----
  logic                     sgn_p1;
  logic [SWIDTH:0]          man_a_p1, man_b_p1;
  logic signed [XW-1:0]     exp_p1;
  logic [2:0]               cls_a_p1, cls_b_p1;  // {nan, inf, zero}

  always_ff @(posedge clk) begin
    if (en_p1 & i_valid) begin
      sgn_p1   <= i_a[W-1] ^ i_b[W-1];
      man_a_p1 <= {|ea, fa};
      man_b_p1 <= {|eb, fb};
      exp_p1   <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
      cls_a_p1 <= {(&ea) & (|fa), (&ea) & ~(|fa), ~(|ea)};
      cls_b_p1 <= {(&eb) & (|fb), (&eb) & ~(|fb), ~(|eb)};
    end
  end

  // ---- stage 2: significand multiply ----
  logic                     sgn_p2;
  logic [PW-1:0]            prod_p2;
  logic signed [XW-1:0]     exp_p2;
  logic [2:0]               cls_p2;  // {nan or inf*zero, inf, zero}

  always_ff @(posedge clk) begin
    if (en_p2 & vld_p1) begin
      sgn_p2  <= sgn_p1;
      prod_p2 <= man_a_p1 * man_b_p1;
      exp_p2  <= exp_p1;
      cls_p2  <= {cls_a_p1[2] | cls_b_p1[2] | (cls_a_p1[1] & cls_b_p1[0]) | (cls_a_p1[0] & cls_b_p1[1]),
                  cls_a_p1[1] | cls_b_p1[1],
                  cls_a_p1[0] | cls_b_p1[0]};
    end
  end

  // ---- stage 3: normalize, round, pack into the output register ----
  logic                     msb;
  logic [PW-2:0]            norm;
  logic [SWIDTH:0]          rnd;
  logic signed [XW-1:0]     exp_n;
  logic [W-1:0]             res;

  assign msb   = prod_p2[PW-1];
  assign norm  = msb ? prod_p2[PW-2:0] : {prod_p2[PW-3:0], 1'b0};
  assign rnd   = rne_round(norm);
  assign exp_n = exp_p2 + $signed({{EWIDTH{1'b0}}, {1'b0, msb} + {1'b0, rnd[SWIDTH]}});
  assign res   = sat_pack(sgn_p2, cls_p2, exp_n, rnd[SWIDTH-1:0]);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      o_p    <= '0;
`ifdef FLP_MUL_PIPE_EXC_EN
      o_exc  <= '0;
`endif
    end else begin
      if (en_p1) vld_p1 <= i_valid;
      if (en_p2) vld_p2 <= vld_p1;
      if (en_p3) vld_p3 <= vld_p2;
      if (en_p3 & vld_p2) begin
        o_p   <= res;
`ifdef FLP_MUL_PIPE_EXC_EN
        o_exc <= exc_flags(cls_p2, exp_n);
`endif
      end
    end
  end

endmodule

// File: tb/tb_flp_mul_pipe.sv
// Directed and randomized checks for flp_mul_pipe in its FP32 configuration.
module tb_flp_mul_pipe;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] a, b, p;
  logic        iv, ordy, ov, irdy;
`ifdef FLP_MUL_PIPE_EXC_EN
  logic [2:0]  exc;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flp_mul_pipe #(.EWIDTH(8), .SWIDTH(23)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .i_a     (a),
    .i_b     (b),
    .i_valid (iv),
    .o_ready (ordy),
    .o_p     (p),
    .o_valid (ov),
`ifdef FLP_MUL_PIPE_EXC_EN
    .o_exc   (exc),
`endif
    .i_ready (irdy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Independent FP32 reference: integer product, remainder-based round to nearest even.
  function automatic logic [31:0] fmul_ref(input logic [31:0] x, input logic [31:0] y);
    logic        s, xn, yn, xi, yi, xz, yz;
    logic [63:0] ma, mb, pr, q, r, half;
    int          e, sh;
    s  = x[31] ^ y[31];
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    xz = (x[30:23] == 8'h00);
    yz = (y[30:23] == 8'h00);
    if (xn || yn || (xi && yz) || (xz && yi)) return 32'h7FC00000;
    if (xi || yi) return {s, 8'hFF, 23'd0};
    if (xz || yz) return {s, 31'd0};
    ma = {40'd0, 1'b1, x[22:0]};
    mb = {40'd0, 1'b1, y[22:0]};
    pr = ma * mb;
    e  = int'(x[30:23]) + int'(y[30:23]) - 127;
    sh = 23;
    if (pr >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end
    q    = pr >> sh;
    r    = pr - (q << sh);
    half = 64'd1 << (sh - 1);
    if (r > half || (r == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int          sel;
    sel = $urandom_range(0, 15);
    if (sel == 0) begin
      case ($urandom_range(0, 3))
        0: e = 8'h00;
        1: e = 8'hFF;
        2: e = 8'h01;
        default: e = 8'hFE;
      endcase
    end else if (sel < 3) e = 8'($urandom_range(0, 255));
    else e = 8'($urandom_range(100, 154));
    f = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  task automatic test_reset();
    nrst = 1'b0; iv = 1'b0; irdy = 1'b1; a = '0; b = '0;
    #3;
    checks++;
    if (ov !== 1'b0 || p !== 32'h0) begin
      errors++;
      $display("FAIL reset_out got valid=%b p=%h want valid=0 p=00000000", ov, p);
    end
    @(negedge clk);
    nrst = 1'b1;
    cyc();
    checks++;
    if (ordy !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", ordy);
    end
  endtask

  task automatic test_latency();
    a = 32'h3F800000; b = 32'h40000000; iv = 1'b1; irdy = 1'b1;
    @(negedge clk);
    checks++;
    if (ordy !== 1'b1) begin
      errors++;
      $display("FAIL lat_accept got ready=%b want 1", ordy);
    end
    cyc();
    iv = 1'b0;
    // cycle t follows the t-th edge counted from the accepting one
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      checks++;
      if (ov !== (t == 3)) begin
        errors++;
        $display("FAIL lat_valid_c%0d got %b want %b", t, ov, (t == 3));
      end
      if (t == 3) begin
        checks++;
        if (p !== 32'h40000000) begin
          errors++;
          $display("FAIL lat_p got %h want 40000000", p);
        end
      end
      cyc();
    end
  endtask

  task automatic test_rounding();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] vp [3];
    int n;
    va = '{32'h3F800001, 32'hBFC00000, 32'h3FC00000};
    vb = '{32'h3F800001, 32'h40000000, 32'h3FC00000};
    vp = '{32'h3F800002, 32'hC0400000, 32'h40100000};
    irdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = va[i]; b = vb[i]; iv = 1'b1;
      cyc();
      iv = 1'b0;
      n = 0;
      while (!ov && n < 10) begin
        cyc();
        n++;
      end
      checks++;
      if (ov !== 1'b1 || p !== vp[i]) begin
        errors++;
        $display("FAIL round_%0d got valid=%b p=%h want p=%h", i, ov, p, vp[i]);
      end
      cyc();
    end
  endtask

  task automatic test_specials();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] vp [6];
    logic [2:0]  ve [6];
    int n;
    va = '{32'h7F800000, 32'h7F000000, 32'h00800000, 32'h80000000, 32'h7FC00001, 32'hFF800000};
    vb = '{32'h00000000, 32'h7F000000, 32'h3F000000, 32'h3F800000, 32'h3F800000, 32'h40000000};
    vp = '{32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h80000000, 32'h7FC00000, 32'hFF800000};
    ve = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b100, 3'b000};
    irdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = va[i]; b = vb[i]; iv = 1'b1;
      cyc();
      iv = 1'b0;
      n = 0;
      while (!ov && n < 10) begin
        cyc();
        n++;
      end
      checks++;
      if (ov !== 1'b1 || p !== vp[i]) begin
        errors++;
        $display("FAIL special_%0d got valid=%b p=%h want p=%h", i, ov, p, vp[i]);
      end
`ifdef FLP_MUL_PIPE_EXC_EN
      checks++;
      if (exc !== ve[i]) begin
        errors++;
        $display("FAIL special_exc_%0d got %b want %b", i, exc, ve[i]);
      end
`else
      if (ve[i] === 3'bxxx) $display("unreachable");
`endif
      cyc();
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] vp [5];
    int sent, rcv;
    va = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h40400000, 32'hC0000000};
    vb = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h3F000000, 32'h40400000};
    vp = '{32'h3F800000, 32'h40800000, 32'h40100000, 32'h3FC00000, 32'hC0C00000};
    sent = 0; rcv = 0;
    for (int c = 0; c < 40 && rcv < 5; c++) begin
      irdy = (c >= 8);
      iv   = (sent < 5);
      if (sent < 5) begin
        a = va[sent]; b = vb[sent];
      end
      @(negedge clk);
      if (c >= 3 && c < 8) begin
        checks++;
        if (ordy !== 1'b0 || ov !== 1'b1 || p !== vp[0] || sent != 3) begin
          errors++;
          $display("FAIL bp_stall_c%0d got ready=%b valid=%b p=%h sent=%0d want ready=0 valid=1 p=%h sent=3",
                   c, ordy, ov, p, sent, vp[0]);
        end
      end
      if (ov && irdy) begin
        checks++;
        if (p !== vp[rcv]) begin
          errors++;
          $display("FAIL bp_out_%0d got %h want %h", rcv, p, vp[rcv]);
        end
        rcv++;
      end
      if (iv && ordy) sent++;
      cyc();
    end
    iv = 1'b0;
    checks++;
    if (rcv != 5 || sent != 5 || ov !== 1'b0) begin
      errors++;
      $display("FAIL bp_count got rcv=%0d sent=%0d valid_after=%b want 5 5 0", rcv, sent, ov);
    end
  endtask

  task automatic test_bubbles();
    logic [3:0] pat;
    logic       want;
    pat = 4'b0101;
    irdy = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
    for (int t = 0; t < 9; t++) begin
      iv = (t < 4) ? pat[t] : 1'b0;
      @(negedge clk);
      want = (t >= 3 && t <= 6) ? pat[t-3] : 1'b0;
      checks++;
      if (ov !== want) begin
        errors++;
        $display("FAIL bubble_c%0d got valid=%b want %b", t, ov, want);
      end
      cyc();
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_q [$];
    logic [31:0] ca, cb;
    int sent, rcv, budget;
    sent = 0; rcv = 0; budget = 0;
    ca = rand_fp(); cb = rand_fp();
    while (rcv < 10000 && budget < 80000) begin
      iv   = (sent < 10000) && ($urandom_range(0, 3) != 0);
      a    = ca; b = cb;
      irdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (ov && irdy) begin
        checks++;
        if (exp_q.size() == 0 || p !== exp_q[0]) begin
          errors++;
          if (errors <= 10)
            $display("FAIL random_%0d got %h want %h", rcv, p, (exp_q.size() != 0) ? exp_q[0] : 32'hx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rcv++;
      end
      if (iv && ordy) begin
        exp_q.push_back(fmul_ref(ca, cb));
        sent++;
        ca = rand_fp(); cb = rand_fp();
      end
      cyc();
      budget++;
    end
    iv = 1'b0; irdy = 1'b1;
    checks++;
    if (rcv != 10000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_count got rcv=%0d pending=%0d want 10000 0", rcv, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    irdy = 1'b1; a = 32'h3F800000; b = 32'h40000000;
    for (int t = 0; t < 3; t++) begin
      iv = 1'b1;
      cyc();
    end
    iv = 1'b0;
    checks++;
    if (ov !== 1'b1) begin
      errors++;
      $display("FAIL midrst_inflight got valid=%b want 1", ov);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (ov !== 1'b0 || p !== 32'h0) begin
      errors++;
      $display("FAIL midrst_async got valid=%b p=%h want 0 00000000", ov, p);
    end
    @(negedge clk);
    nrst = 1'b1;
    for (int t = 0; t < 6; t++) begin
      cyc();
      checks++;
      if (ov !== 1'b0 || ordy !== 1'b1) begin
        errors++;
        $display("FAIL midrst_after_c%0d got valid=%b ready=%b want 0 1", t, ov, ordy);
      end
    end
  endtask

  initial begin
    nrst = 1'b0; iv = 1'b0; irdy = 1'b1; a = '0; b = '0;
    test_reset();
    test_latency();
    test_rounding();
    test_specials();
    test_back_pressure();
    test_bubbles();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
